// File: rtl/ram16_word_master.sv
// rtl/ram16_word_master.sv - 32-bit word port to 16-bit RAM bridge, two halfword accesses per word
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   cpu_address[31:0]        byte address, bits [12:2] select the word (upper bits alias)
//   cpu_read, cpu_write      request strobes, held until cpu_waitrequest is low; write wins
//   cpu_byteenable[3:0]      write byte lanes
//   cpu_writedata[31:0]      write data
//   cpu_readdata[31:0]       read data, valid in the completion cycle and held until the next read
//   cpu_waitrequest          high while a request is present and not yet complete
//   mem_address[31:0]        halfword index {word, h}
//   mem_read, mem_write      RAM strobes, one cycle per halfword
//   mem_writedata[31:0]      halfword in bits [15:0]
//   mem_readdata[31:0]       combinational RAM output, bits [15:0] used

module ram16_word_master (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] cpu_address,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [3:0]  cpu_byteenable,
   input  logic [31:0] cpu_writedata,
   output logic [31:0] cpu_readdata,
   output logic        cpu_waitrequest,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state;
   state_t      state_nx;

   logic [10:0] word_q;
   logic        wr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;

   logic        cpu_req;
   logic        access;
   logic        half;
   logic [1:0]  hbe;
   logic [15:0] hdata;

   // Address bits outside the word index and the RAM's upper data bits are don't-care.
   logic        unused_bits;
   assign unused_bits = ^{cpu_address[31:13], cpu_address[1:0], mem_readdata[31:16]};

   assign cpu_req = cpu_read | cpu_write;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Request is captured once; the bus runs off these copies for the whole transaction.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         word_q  <= '0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (state == IDLE && cpu_req) begin
         word_q  <= cpu_address[12:2];
         wr_q    <= cpu_write;
         be_q    <= cpu_byteenable;
         wdata_q <= cpu_writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cpu_readdata <= '0;
      end else if (!wr_q && state == LO) begin
         cpu_readdata[15:0] <= mem_readdata[15:0];
      end else if (!wr_q && state == HI) begin
         cpu_readdata[31:16] <= mem_readdata[15:0];
      end
   end

   always_comb begin
      state_nx        = state;
      cpu_waitrequest = 1'b0;
      access          = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               cpu_waitrequest = 1'b1;
               state_nx        = LO;
            end
         end
         LO: begin
            cpu_waitrequest = 1'b1;
            access          = 1'b1;
            state_nx        = HI;
         end
         HI: begin
            cpu_waitrequest = 1'b1;
            access          = 1'b1;
            state_nx        = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // RAM side. Strobes are masked while reset_n is low so an aborted transaction
   // cannot write on the reset edge.
   always_comb begin
      mem_address   = '0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_writedata = '0;
      half          = (state == HI);
      hbe           = half ? be_q[3:2] : be_q[1:0];
      hdata         = half ? wdata_q[31:16] : wdata_q[15:0];
      if (access && reset_n) begin
         mem_address = {20'b0, word_q, half};
         if (!wr_q) begin
            mem_read = 1'b1;
         end else begin
            // Single-byte halfwords merge with the current RAM contents in the same cycle.
            case (hbe)
               2'b11: begin
                  mem_write     = 1'b1;
                  mem_writedata = {16'b0, hdata};
               end
               2'b01: begin
                  mem_read      = 1'b1;
                  mem_write     = 1'b1;
                  mem_writedata = {16'b0, mem_readdata[15:8], hdata[7:0]};
               end
               2'b10: begin
                  mem_read      = 1'b1;
                  mem_write     = 1'b1;
                  mem_writedata = {16'b0, hdata[15:8], mem_readdata[7:0]};
               end
               default: begin
                  mem_write = 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ram16_word_master.sv
// tb/tb_ram16_word_master.sv - scoreboard bench for ram16_word_master with a behavioural RAM
//
// Ports: none (top-level bench).

module tb_ram16_word_master;

   logic        clk;
   logic        reset_n;
   logic [31:0] cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [3:0]  cpu_byteenable;
   logic [31:0] cpu_writedata;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;

   ram16_word_master dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cpu_address    (cpu_address),
      .cpu_read       (cpu_read),
      .cpu_write      (cpu_write),
      .cpu_byteenable (cpu_byteenable),
      .cpu_writedata  (cpu_writedata),
      .cpu_readdata   (cpu_readdata),
      .cpu_waitrequest(cpu_waitrequest),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_readdata   (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical RAM: combinational read, clocked write.
   logic [15:0] ram [0:4095];
   assign mem_readdata = {16'b0, ram[mem_address[11:0]]};
   always @(posedge clk) begin
      if (mem_write) ram[mem_address[11:0]] <= mem_writedata[15:0];
   end

   // Reference model: halfword array plus the last read word.
   logic [15:0] ref_ram [0:4095];
   logic [31:0] model_rdata;

   typedef struct packed {
      logic        is_wr;
      logic [11:0] base;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic [15:0] new_lo;
      logic [15:0] new_hi;
   } txn_t;

   txn_t q[$];

   int checks = 0;
   int errors = 0;
   logic mon_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: walks each transaction cycle by cycle against the queued expectation.
   int          cyc = 0;
   txn_t        cur;
   logic [1:0]  e;
   logic        exp_rd;
   logic        exp_wr;
   logic [15:0] exp_half;

   always @(negedge clk) begin
      if (!reset_n || !mon_en) begin
         cyc = 0;
      end else if (cyc == 0) begin
         if (cpu_read || cpu_write) begin
            if (q.size() == 0) begin
               chk("unexpected_request", 32'd1, 32'd0);
            end else begin
               cur = q[0];
               chk("wait_c0", cpu_waitrequest, 1'b1);
               chk("strobes_c0", {mem_read, mem_write}, 2'b00);
               cyc = 1;
            end
         end else begin
            chk("idle_wait", cpu_waitrequest, 1'b0);
            chk("idle_strobes", {mem_read, mem_write}, 2'b00);
         end
      end else if (cyc == 1 || cyc == 2) begin
         e        = (cyc == 2) ? cur.be[3:2] : cur.be[1:0];
         exp_half = (cyc == 2) ? cur.new_hi : cur.new_lo;
         if (!cur.is_wr) begin
            exp_rd = 1'b1;
            exp_wr = 1'b0;
         end else begin
            exp_wr = (e != 2'b00);
            exp_rd = (e == 2'b01) || (e == 2'b10);
         end
         chk("wait_busy", cpu_waitrequest, 1'b1);
         chk("mem_read", mem_read, exp_rd);
         chk("mem_write", mem_write, exp_wr);
         if (exp_rd || exp_wr)
            chk("mem_address", mem_address, {20'b0, cur.base[11:1], (cyc == 2)});
         if (exp_wr)
            chk("mem_writedata", mem_writedata, {16'b0, exp_half});
         cyc = cyc + 1;
      end else begin
         chk("wait_done", cpu_waitrequest, 1'b0);
         chk("strobes_done", {mem_read, mem_write}, 2'b00);
         chk("readdata", cpu_readdata, cur.exp_rdata);
         chk("ram_lo", {16'b0, ram[cur.base]}, {16'b0, cur.new_lo});
         chk("ram_hi", {16'b0, ram[cur.base | 12'd1]}, {16'b0, cur.new_hi});
         void'(q.pop_front());
         cyc = 0;
      end
   end

   // Called at posedge+1; returns at posedge+1 with the request dropped.
   task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
      txn_t        t;
      logic [31:0] old_w;
      logic [31:0] new_w;
      t.is_wr = wr;
      t.base  = {addr[12:2], 1'b0};
      t.be    = be;
      old_w   = {ref_ram[t.base | 12'd1], ref_ram[t.base]};
      new_w   = old_w;
      if (wr) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
      end else begin
         model_rdata = old_w;
      end
      t.exp_rdata = model_rdata;
      t.new_lo    = new_w[15:0];
      t.new_hi    = new_w[31:16];
      ref_ram[t.base]         = new_w[15:0];
      ref_ram[t.base | 12'd1] = new_w[31:16];
      q.push_back(t);
      cpu_address    = addr;
      cpu_read       = rd;
      cpu_write      = wr;
      cpu_byteenable = be;
      cpu_writedata  = wd;
      repeat (4) @(posedge clk);
      #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] w;
      int          op;
      logic [31:0] a;
      reset_n        = 1'b0;
      mon_en         = 1'b1;
      cpu_address    = '0;
      cpu_read       = 1'b0;
      cpu_write      = 1'b0;
      cpu_byteenable = '0;
      cpu_writedata  = '0;
      model_rdata    = '0;
      for (int i = 0; i < 4096; i++) begin
         ram[i]     = 16'h0;
         ref_ram[i] = 16'h0;
      end

      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_readdata", cpu_readdata, 32'h0);
      chk("rst_wait", cpu_waitrequest, 1'b0);
      chk("rst_mem_rd_wr", {mem_read, mem_write}, 2'b00);
      chk("rst_mem_address", mem_address, 32'h0);
      chk("rst_mem_writedata", mem_writedata, 32'h0);
      @(posedge clk);
      #1;

      do_txn(1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
      chk("full_ram8", {16'b0, ram[8]}, 32'h0000BEEF);
      chk("full_ram9", {16'b0, ram[9]}, 32'h0000DEAD);

      do_txn(1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);
      chk("read_held", cpu_readdata, 32'hDEADBEEF);
      do_txn(1'b1, 1'b0, 32'h2010, 4'b0000, 32'h0);
      chk("alias_read_held", cpu_readdata, 32'hDEADBEEF);

      do_txn(1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00);
      chk("partial_ram8", {16'b0, ram[8]}, 32'h0000AAEF);
      chk("partial_ram9", {16'b0, ram[9]}, 32'h0000DEAD);
      chk("write_keeps_readdata", cpu_readdata, 32'hDEADBEEF);

      do_txn(1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
      chk("null_ram8", {16'b0, ram[8]}, 32'h0000AAEF);
      do_txn(1'b1, 1'b1, 32'h10, 4'b1111, 32'h12345678);
      chk("conflict_ram8", {16'b0, ram[8]}, 32'h00005678);
      chk("conflict_ram9", {16'b0, ram[9]}, 32'h00001234);

      // Reset in the HI cycle of a full write; driven by hand, outside the scoreboard.
      mon_en         = 1'b0;
      cpu_address    = 32'h10;
      cpu_write      = 1'b1;
      cpu_byteenable = 4'b1111;
      cpu_writedata  = 32'hCAFEF00D;
      repeat (2) @(posedge clk);
      #1;
      reset_n   = 1'b0;
      cpu_write = 1'b0;
      #1;
      chk("rst_hi_no_write", mem_write, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      chk("midrst_ram8", {16'b0, ram[8]}, 32'h0000F00D);
      chk("midrst_ram9", {16'b0, ram[9]}, 32'h00001234);
      chk("midrst_readdata", cpu_readdata, 32'h0);
      chk("midrst_wait", cpu_waitrequest, 1'b0);
      ref_ram[8]  = 16'hF00D;
      model_rdata = 32'h0;
      idle(1);
      mon_en = 1'b1;
      do_txn(1'b1, 1'b0, 32'hFFFF0010, 4'b0000, 32'h0);
      chk("after_midrst_read", cpu_readdata, 32'h1234F00D);

      for (int n = 0; n < 250; n++) begin
         w  = ($urandom_range(0, 9) == 0) ? 11'd2047 : 11'($urandom_range(0, 7));
         a  = ($urandom & 32'hFFFFE003) | {19'b0, w, 2'b00};
         op = $urandom_range(0, 2);
         do_txn(op != 1, op != 0, a, 4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      idle(3);
      chk("queue_empty", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
